instr_cache: RTL and testbench

Direct-mapped instruction cache between the CPU's PC and a multi-cycle main memory, replacing the ideal single-cycle instruction memory in the fetch path. Hits return the instruction combinationally in the same cycle, so the single-cycle datapath is unchanged. A miss raises `stall`, which freezes PC and register/flag writes. A fill FSM then fetches the 8-word block as pipelined word reads.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/icache_tag_array.sv | 50 +++++
 rtl/instr_cache.sv | 160 ++++++++++++++++
 tb/tb_instr_cache.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, fill FSM state and address-split helpers
// Purpose: common definitions for instr_cache and its tag array.
// Contents: default geometry constants, state_t (IDLE/FILL), and helpers that
//           split a 16-bit byte address into offset, index and tag fields.
package cache_pkg;

   localparam int WORDS_PER_BLOCK = 8;
   localparam int IDX_W           = 5;
   localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);
   localparam int TAG_W           = 16 - 1 - IDX_W - OFF_W;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   // Helpers return a right-justified field in 16 bits; callers cast to width.
   // Bit 0 of the byte address is always dropped (16-bit instruction words).
   function automatic logic [15:0] addr_off(input logic [15:0] a, input int off_w);
      return (a >> 1) & ((16'd1 << off_w) - 16'd1);
   endfunction

   function automatic logic [15:0] addr_idx(input logic [15:0] a, input int off_w,
                                            input int idx_w);
      return (a >> (1 + off_w)) & ((16'd1 << idx_w) - 16'd1);
   endfunction

   function automatic logic [15:0] addr_tag(input logic [15:0] a, input int off_w,
                                            input int idx_w);
      return a >> (1 + off_w + idx_w);
   endfunction

endpackage

// File: rtl/icache_tag_array.sv
// rtl/icache_tag_array.sv - valid bits and tags for the direct-mapped instruction cache
// Purpose: per-set valid bit and tag with asynchronous read, one write port and
//          a whole-array valid clear.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears valid only)
//   rd_idx              set being looked up; rd_valid/rd_tag returned combinationally
//   wr_en, wr_idx       write one set: tag <= wr_tag, valid <= wr_valid
//   wr_valid, wr_tag
//   clr_all             clear every valid bit; overrides wr_en
module icache_tag_array #(
   parameter int NUM_SETS = 32,
   parameter int TAG_W    = 7,
   parameter int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_valid,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             clr_all
);

   logic [NUM_SETS-1:0] valid;
   logic [TAG_W-1:0]    tags [NUM_SETS];

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else if (clr_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= wr_valid;
      end
   end

   // Tags carry no reset: a tag is only meaningful while its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en && !clr_all) begin
         tags[wr_idx] <= wr_tag;
      end
   end

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped instruction cache with 8-word block fill FSM
// Purpose: sits between the CPU PC and a multi-cycle main memory. Hits return
//          the word combinationally; a miss stalls the CPU while the block is
//          fetched with back-to-back pipelined word reads.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rd_en, addr         fetch request and byte address (PC)
//   flush               invalidate all lines (deferred to fill end while filling)
//   data_out            instruction word, valid when rd_en && !stall
//   stall               miss in progress; CPU holds PC and suppresses writes
//   mem_rd_en, mem_addr registered word read request to main memory
//   mem_data_in         returned word, qualified by mem_data_valid
//   mem_data_valid      responses arrive in request order
module instr_cache #(
   parameter int NUM_SETS        = 1 << cache_pkg::IDX_W,
   parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic [15:0] addr,
   input  logic        flush,
   output logic [15:0] data_out,
   output logic        stall,
   output logic        mem_rd_en,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data_in,
   input  logic        mem_data_valid
);

   import cache_pkg::*;

   localparam int OFF_BITS = $clog2(WORDS_PER_BLOCK);
   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = 15 - OFF_BITS - IDX_BITS;
   localparam logic [OFF_BITS:0] BLOCK_CNT = (OFF_BITS + 1)'(WORDS_PER_BLOCK);
   localparam logic [OFF_BITS:0] LAST_CNT  = (OFF_BITS + 1)'(WORDS_PER_BLOCK - 1);

   state_t              state;
   logic [TAG_BITS-1:0] cur_tag, fill_tag, rd_tag, tag_wtag;
   logic [IDX_BITS-1:0] cur_idx, fill_idx, tag_widx;
   logic [OFF_BITS-1:0] cur_off;
   logic [OFF_BITS:0]   req_cnt, rsp_cnt;
   logic                flush_pend, rd_valid, hit, miss, last_rsp;
   logic                tag_we, tag_wvalid, clr_all;
   logic [15:0]         data_mem [NUM_SETS * WORDS_PER_BLOCK];

   assign cur_off = OFF_BITS'(addr_off(addr, OFF_BITS));
   assign cur_idx = IDX_BITS'(addr_idx(addr, OFF_BITS, IDX_BITS));
   assign cur_tag = TAG_BITS'(addr_tag(addr, OFF_BITS, IDX_BITS));

   icache_tag_array #(
      .NUM_SETS (NUM_SETS),
      .TAG_W    (TAG_BITS),
      .IDX_W    (IDX_BITS)
   ) u_tags (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (cur_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .wr_en    (tag_we),
      .wr_idx   (tag_widx),
      .wr_valid (tag_wvalid),
      .wr_tag   (tag_wtag),
      .clr_all  (clr_all)
   );

   // Lookups only count as hits in IDLE, so addr changes during a fill are ignored.
   assign hit      = rd_en && rd_valid && (rd_tag == cur_tag) && (state == IDLE);
   assign miss     = rd_en && !hit;
   assign stall    = miss || (state != IDLE);
   assign data_out = hit ? data_mem[{cur_idx, cur_off}] : 16'h0000;
   assign last_rsp = (state == FILL) && mem_data_valid && (rsp_cnt == LAST_CNT);

   always_comb begin
      tag_we     = 1'b0;
      tag_wvalid = 1'b0;
      tag_widx   = cur_idx;
      tag_wtag   = cur_tag;
      clr_all    = 1'b0;
      if (state == IDLE) begin
         if (flush) begin
            clr_all = 1'b1;
         end else if (miss) begin
            // Victim line goes invalid while its data is being overwritten.
            tag_we = 1'b1;
         end
      end else if (last_rsp) begin
         if (flush || flush_pend) begin
            clr_all = 1'b1;
         end else begin
            tag_we     = 1'b1;
            tag_wvalid = 1'b1;
            tag_widx   = fill_idx;
            tag_wtag   = fill_tag;
         end
      end
   end

   // req_cnt counts requests already launched. The first request is launched on
   // the miss edge itself so the 8 requests occupy the 8 cycles after the miss.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         req_cnt    <= '0;
         rsp_cnt    <= '0;
         flush_pend <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= 16'h0000;
         fill_tag   <= '0;
         fill_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_rd_en <= 1'b0;
               if (miss) begin
                  state     <= FILL;
                  fill_tag  <= cur_tag;
                  fill_idx  <= cur_idx;
                  rsp_cnt   <= '0;
                  req_cnt   <= (OFF_BITS + 1)'(1);
                  mem_rd_en <= 1'b1;
                  mem_addr  <= {cur_tag, cur_idx, {OFF_BITS{1'b0}}, 1'b0};
               end
            end
            FILL: begin
               if (flush) begin
                  flush_pend <= 1'b1;
               end
               if (req_cnt < BLOCK_CNT) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= {fill_tag, fill_idx, req_cnt[OFF_BITS-1:0], 1'b0};
                  req_cnt   <= req_cnt + 1'b1;
               end else begin
                  mem_rd_en <= 1'b0;
               end
               if (mem_data_valid) begin
                  rsp_cnt <= rsp_cnt + 1'b1;
               end
               if (last_rsp) begin
                  state      <= IDLE;
                  flush_pend <= 1'b0;
                  req_cnt    <= '0;
                  rsp_cnt    <= '0;
                  mem_rd_en  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state == FILL) && mem_data_valid) begin
         data_mem[{fill_idx, rsp_cnt[OFF_BITS-1:0]}] <= mem_data_in;
      end
   end

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - self-checking bench for instr_cache with a latency-4 memory model
module tb_instr_cache;

   localparam int LAT = 4;
   localparam int MISS_STALL = 9 + LAT;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_en = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] mem_data_in = 16'h0000;
   logic        mem_data_valid = 1'b0;
   logic [15:0] data_out;
   logic        stall;
   logic        mem_rd_en;
   logic [15:0] mem_addr;

   int tests = 0;
   int fails = 0;

   logic [15:0] memw [32768];
   bit          pv [16];
   logic [15:0] pd [16];
   int          cyc_cnt = 0;
   bit          stray = 1'b0;

   bit          model_valid [32];
   logic [6:0]  model_tag [32];

   always #5 clk = ~clk;

   instr_cache dut (
      .clk            (clk),
      .rst            (rst),
      .rd_en          (rd_en),
      .addr           (addr),
      .flush          (flush),
      .data_out       (data_out),
      .stall          (stall),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .mem_data_valid (mem_data_valid)
   );

   // Main memory: a request seen in cycle t returns in cycle t+LAT.
   // In stray mode every cycle carries a bogus response and the pipe is dropped.
   always @(posedge clk) begin
      #1;
      cyc_cnt++;
      if (stray) begin
         mem_data_valid = 1'b1;
         mem_data_in    = 16'($urandom);
         for (int i = 0; i < 16; i++) pv[i] = 1'b0;
      end else begin
         mem_data_valid = pv[cyc_cnt % 16];
         mem_data_in    = pd[cyc_cnt % 16];
         pv[cyc_cnt % 16] = 1'b0;
      end
      if (mem_rd_en) begin
         pv[(cyc_cnt + LAT) % 16] = 1'b1;
         pd[(cyc_cnt + LAT) % 16] = memw[mem_addr[15:1]];
      end
   end

   function automatic bit model_hit(input logic [15:0] a);
      int s;
      s = int'(a >> 4) % 32;
      return model_valid[s] && (model_tag[s] == 7'(a >> 9));
   endfunction

   task automatic model_fill(input logic [15:0] a);
      int s;
      s = int'(a >> 4) % 32;
      model_valid[s] = 1'b1;
      model_tag[s]   = 7'(a >> 9);
   endtask

   task automatic model_clear();
      foreach (model_valid[i]) model_valid[i] = 1'b0;
   endtask

   // Fetch a, optionally switching to alt at chg_cyc and pulsing flush at flush_cyc.
   // Checks every memory request (address and cycle), the stall length, the
   // number of requests and the delivered word.
   task automatic fetch(input logic [15:0] a, input logic [15:0] alt, input int chg_cyc,
                        input int flush_cyc, input int exp_stall, input int exp_nreq,
                        input string name);
      int          cyc, nreq, exp_cyc;
      logic [15:0] exp_addr, dest;
      bit          timed_out;
      cyc = 0; nreq = 0; timed_out = 1'b0;
      dest = (chg_cyc >= 0) ? alt : a;
      @(posedge clk); #1;
      rd_en = 1'b1; addr = a; flush = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_rd_en) begin
            exp_addr = (nreq < 8) ? ((a & 16'hFFF0) + 16'(2 * nreq))
                                  : ((alt & 16'hFFF0) + 16'(2 * (nreq - 8)));
            exp_cyc  = (nreq < 8) ? nreq + 1 : nreq + LAT + 2;
            tests++;
            if (mem_addr !== exp_addr || cyc != exp_cyc) begin
               fails++;
               $display("FAIL %s mem_req[%0d]: addr=%h cycle=%0d, required addr=%h cycle=%0d",
                        name, nreq, mem_addr, cyc, exp_addr, exp_cyc);
            end
            nreq++;
         end
         if (stall === 1'b0) break;
         cyc++;
         if (cyc > 200) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (cyc == chg_cyc) addr = alt;
         flush = (cyc == flush_cyc);
      end
      flush = 1'b0;
      tests++;
      if (timed_out) begin
         fails++;
         $display("FAIL %s timeout: stall still %b after 200 cycles", name, stall);
      end
      tests++;
      if (cyc != exp_stall) begin
         fails++;
         $display("FAIL %s stall_len: got %0d cycles, required %0d", name, cyc, exp_stall);
      end
      tests++;
      if (nreq != exp_nreq) begin
         fails++;
         $display("FAIL %s req_count: got %0d, required %0d", name, nreq, exp_nreq);
      end
      tests++;
      if (data_out !== memw[dest[15:1]]) begin
         fails++;
         $display("FAIL %s data: got %h, required %h", name, data_out, memw[dest[15:1]]);
      end
   endtask

   task automatic access(input logic [15:0] a, input string name);
      bit h;
      h = model_hit(a);
      fetch(a, a, -1, -1, h ? 0 : MISS_STALL, h ? 0 : 8, name);
      model_fill(a);
   endtask

   task automatic test_reset();
      rd_en = 1'b1; addr = 16'h0040;
      @(negedge clk);
      tests++;
      if (stall !== 1'b1 || data_out !== 16'h0000 || mem_rd_en !== 1'b0 || mem_addr !== 16'h0000) begin
         fails++;
         $display("FAIL reset_outputs: stall=%b data=%h mem_rd_en=%b mem_addr=%h, required 1 0000 0 0000",
                  stall, data_out, mem_rd_en, mem_addr);
      end
      rd_en = 1'b0;
      #1;
      tests++;
      if (stall !== 1'b0) begin
         fails++;
         $display("FAIL reset_stall_idle: stall=%b, required 0", stall);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_first_miss();
      access(16'h0040, "first_miss");
   endtask

   task automatic test_hit();
      access(16'h004E, "hit_004E");
      for (int i = 0; i < 4; i++) begin
         access(16'h0040 | 16'($urandom_range(0, 7) << 1), "hit_line4");
      end
   endtask

   task automatic test_conflict();
      access(16'h0240, "conflict_0240");
      access(16'h0040, "conflict_back_0040");
   endtask

   task automatic test_addr_change();
      access(16'h0240, "evict_0040");
      fetch(16'h0040, 16'h1000, 3, -1, 2 * MISS_STALL, 16, "addr_change");
      model_fill(16'h0040);
      model_fill(16'h1000);
      access(16'h0040, "addr_change_kept");
   endtask

   task automatic test_flush();
      fetch(16'h0800, 16'h0800, -1, 2, 2 * MISS_STALL, 16, "flush_in_fill");
      model_clear();
      model_fill(16'h0800);
      access(16'h0040, "refetch_after_flush");
      access(16'h0040, "hit_before_idle_flush");
      @(posedge clk); #1;
      rd_en = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      model_clear();
      access(16'h0040, "after_idle_flush");
   endtask

   task automatic test_reset_mid_fill();
      bit bad;
      @(posedge clk); #1;
      rd_en = 1'b1; addr = 16'h3460;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      tests++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 16'h3468) begin
         fails++;
         $display("FAIL mid_fill_req: mem_rd_en=%b mem_addr=%h, required 1 3468", mem_rd_en, mem_addr);
      end
      rst = 1'b0; stray = 1'b1; rd_en = 1'b0;
      #1;
      tests++;
      if (mem_rd_en !== 1'b0 || mem_addr !== 16'h0000 || stall !== 1'b0) begin
         fails++;
         $display("FAIL mid_fill_reset: mem_rd_en=%b mem_addr=%h stall=%b, required 0 0000 0",
                  mem_rd_en, mem_addr, stall);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (mem_rd_en !== 1'b0 || stall !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL stray_ignored: activity seen with rd_en=0 during stray responses, required none");
      end
      stray = 1'b0;
      model_clear();
      access(16'h0040, "after_reset_miss");
   endtask

   task automatic test_idle_no_req();
      bit bad;
      bad = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         rd_en = 1'b0; addr = 16'($urandom);
         @(negedge clk);
         if (stall !== 1'b0 || data_out !== 16'h0000 || mem_rd_en !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL idle_no_req: outputs active with rd_en=0, required stall=0 data=0 mem_rd_en=0");
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      for (int n = 0; n < 40; n++) begin
         a = 16'(($urandom_range(0, 2) << 9) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1));
         access(a, "random_seq");
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) memw[i] = 16'($urandom);
      test_reset();
      test_first_miss();
      test_hit();
      test_conflict();
      test_addr_change();
      test_flush();
      test_reset_mid_fill();
      test_idle_no_req();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at 2000000, required completion");
      $fatal(1, "watchdog");
   end

endmodule
